// File: rtl/mire_pkg.sv
// mire_pkg: shared types and constants for the framebuffer test-pattern writer.
package mire_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, YIELD, DONE} mire_state_e;

  localparam int          WORD_BYTES = 4;
  localparam logic [3:0]  GRID_MASK  = 4'hF;
  localparam logic [23:0] GRID_COLOR = 24'hFFFFFF;
  localparam logic [23:0] BG_COLOR   = 24'h000000;

  // Grid line every 16 pixels in both directions, packed as {8'h00, RGB}
  function automatic logic [31:0] mire_word(input logic [3:0] xl, input logic [3:0] yl);
    return {8'h00, (((xl & GRID_MASK) == 4'h0) || ((yl & GRID_MASK) == 4'h0)) ? GRID_COLOR : BG_COLOR};
  endfunction

endpackage

// File: rtl/wshb_if.sv
// wshb_if: 32-bit Wishbone bus bundle between a master and a slave.
interface wshb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  input  dat_sm, ack, err);
  modport slave  (input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  output dat_sm, ack, err);
endinterface

// File: rtl/mire_xy_counter.sv
// mire_xy_counter: raster pixel position, wraps at end of line and end of frame.
module mire_xy_counter import mire_pkg::*; #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  localparam int XW = $clog2(HDISP),
  localparam int YW = $clog2(VDISP)
) (
  input  logic          wshb_clk,
  input  logic          wshb_rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic x_end;

  // End-of-line and end-of-frame decode
  always_comb begin
    x_end = (x == XW'(HDISP-1));
    last  = x_end && (y == YW'(VDISP-1));
  end

  // Position register; clear wins over advance, last pixel wraps to (0,0)
  always_ff @(posedge wshb_clk) begin
    if (!wshb_rst_n || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_end) begin
        x <= '0;
        y <= last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mire_writer.sv
// mire_writer: Wishbone master filling the framebuffer with a 16-pixel grid.
// Writes bursts of BURST words, then releases the bus for GAP cycles.
// Define MIRE_LOOP_EN to restart at address 0 after each frame while enabled;
// otherwise the writer parks in DONE until enable drops.
module mire_writer import mire_pkg::*; #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BURST = 64,
  parameter int GAP   = 8
) (
  input  logic   wshb_clk,
  input  logic   wshb_rst_n,
  input  logic   enable,
  output logic   frame_done,
  output logic   busy,
  wshb_if.master wshb_ifm
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  mire_state_e   state, state_d;
  logic [XW-1:0] x, nx, px;
  logic [YW-1:0] y, ny, py;
  logic          last, ack_w, burst_end, gap_end;
  logic [BW-1:0] burst_cnt;
  logic [GW-1:0] gap_cnt;
  logic [31:0]   adr_q, dat_q;
  logic          cyc_q, we_q;
  logic          cyc_d, busy_d, done_d;
  logic          unused_sm;

  assign wshb_ifm.cyc    = cyc_q;
  assign wshb_ifm.stb    = cyc_q;
  assign wshb_ifm.we     = we_q;
  assign wshb_ifm.adr    = adr_q;
  assign wshb_ifm.dat_ms = dat_q;
  assign wshb_ifm.sel    = 4'hF;
  assign wshb_ifm.cti    = 3'b000;
  assign wshb_ifm.bte    = 2'b00;
  // Read data and err are not used; err simply never counts as an ack
  assign unused_sm = ^{wshb_ifm.dat_sm, wshb_ifm.err};

  assign ack_w     = (state == WRITE) && wshb_ifm.ack;
  assign burst_end = (burst_cnt == BW'(BURST-1));
  assign gap_end   = (gap_cnt == GW'(GAP-1));

  mire_xy_counter #(.HDISP(HDISP), .VDISP(VDISP)) u_xy (
    .wshb_clk  (wshb_clk),
    .wshb_rst_n(wshb_rst_n),
    .clear     (state_d == IDLE),
    .advance   (ack_w),
    .x         (x),
    .y         (y),
    .last      (last)
  );

  // Look-ahead position so the next word is ready on the edge after ack
  always_comb begin
    nx = x + 1'b1;
    ny = y;
    if (x == XW'(HDISP-1)) begin
      nx = '0;
      ny = last ? '0 : y + 1'b1;
    end
    px = ack_w ? nx : x;
    py = ack_w ? ny : y;
  end

  // State register
  always_ff @(posedge wshb_clk) begin
    if (!wshb_rst_n) state <= IDLE;
    else             state <= state_d;
  end

  // Next state; enable only matters on ack, at gap end, in IDLE and in DONE
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (enable) state_d = WRITE;
      WRITE: if (wshb_ifm.ack) begin
               if (last)           state_d = DONE;
               else if (!enable)   state_d = IDLE;
               else if (burst_end) state_d = YIELD;
             end
      YIELD: if (gap_end) state_d = enable ? WRITE : IDLE;
`ifdef MIRE_LOOP_EN
      DONE:  state_d = enable ? WRITE : IDLE;
`else
      DONE:  if (!enable) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, registered below
  always_comb begin
    cyc_d  = (state_d == WRITE);
    busy_d = (state_d == WRITE) || (state_d == YIELD);
    done_d = (state_d == DONE) && (state != DONE);
  end

  // Registered control outputs
  always_ff @(posedge wshb_clk) begin
    if (!wshb_rst_n) begin
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cyc_q      <= cyc_d;
      we_q       <= cyc_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

  // Address and pixel word; both hold across wait states
  always_ff @(posedge wshb_clk) begin
    if (!wshb_rst_n) begin
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      if (state_d == IDLE) adr_q <= '0;
      else if (ack_w)      adr_q <= last ? '0 : adr_q + 32'(WORD_BYTES);
      if (state_d == WRITE) dat_q <= mire_word(4'(px), 4'(py));
    end
  end

  // Burst length and bus-release gap counters
  always_ff @(posedge wshb_clk) begin
    if (!wshb_rst_n || state_d == IDLE || state_d == DONE) burst_cnt <= '0;
    else if (ack_w) burst_cnt <= burst_end ? '0 : burst_cnt + 1'b1;
    if (!wshb_rst_n || state != YIELD) gap_cnt <= '0;
    else                               gap_cnt <= gap_cnt + 1'b1;
  end

endmodule
